// File: rtl/ternary_pkg.sv
// Shared constants and types for the ternary weight stream unpacker.
// Five base-3 trits per byte, each trit mapped to a 2-bit signed weight code.
package ternary_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned TRITS_PER_BYTE = 5;
  localparam int unsigned WBITS_PER_BYTE = 10;
  localparam int unsigned MAX_CODE       = 242;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;

  typedef enum logic [1:0] {
    TRIT_0 = 2'd0,
    TRIT_1 = 2'd1,
    TRIT_2 = 2'd2
  } trit_e;

  typedef struct packed {
    logic [WBITS_PER_BYTE-1:0] w;
    logic                      err;
  } lane_dec_t;

  // Trit value 0/1/2 to weight code 0/+1/-1.
  function automatic logic [1:0] trit_code(input logic [1:0] t);
    logic [1:0] c;
    c = W_NEG;
    if (t == 2'(TRIT_0)) c = W_ZERO;
    else if (t == 2'(TRIT_1)) c = W_POS;
    return c;
  endfunction

endpackage

// File: rtl/ternary_lane_decode.sv
// Combinational decode of one packed byte into five 2-bit ternary weights.
// Codes above MAX_CODE flag an error; a masked lane always yields zero.
module ternary_lane_decode
  import ternary_pkg::*;
(
  input  logic [BYTE_W-1:0]         data_i,
  input  logic                      keep_i,
  output logic [WBITS_PER_BYTE-1:0] w_o,
  output logic                      err_o
);

  logic [BYTE_W-1:0] rem;
  logic [1:0]        trit;

  // Peel off base-3 digits least significant first.
  always_comb begin
    rem   = data_i;
    trit  = 2'd0;
    w_o   = '0;
    err_o = 1'b0;
    if (keep_i) begin
      if (data_i > BYTE_W'(MAX_CODE)) begin
        err_o = 1'b1;
      end else begin
        for (int unsigned i = 0; i < TRITS_PER_BYTE; i++) begin
          trit         = 2'(rem % BYTE_W'(3));
          w_o[2*i +: 2] = trit_code(trit);
          rem          = rem / BYTE_W'(3);
        end
      end
    end
  end

endmodule

// File: rtl/ternary_stream_unpacker.sv
// Two-stage valid/ready pipeline unpacking LANES ternary-coded bytes per beat.
// Optional saturating error counter enabled by macro TERNARY_ERR_CNT_EN.
module ternary_stream_unpacker
  import ternary_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BYTE_W*LANES-1:0]          in_data,
  input  logic [LANES-1:0]                 in_keep,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WBITS_PER_BYTE*LANES-1:0]  out_w,
  output logic [LANES-1:0]                 out_err_lane,
  output logic                             out_err
`ifdef TERNARY_ERR_CNT_EN
  ,
  input  logic                             err_clr,
  output logic [CNT_W-1:0]                 err_cnt
`endif
);

  localparam int unsigned DW = BYTE_W * LANES;
  localparam int unsigned WW = WBITS_PER_BYTE * LANES;

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [LANES-1:0] s1_keep_q, s1_keep_d;
  logic          s2_valid_q, s2_valid_d;
  logic [WW-1:0] s2_w_q, s2_w_d;
  logic [LANES-1:0] s2_err_q, s2_err_d;
  logic          s2_any_q, s2_any_d;

  logic          s1_adv, s2_adv;
  logic [WW-1:0] dec_w;
  logic [LANES-1:0] dec_err;

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    ternary_lane_decode u_dec (
      .data_i (s1_data_q[BYTE_W*k +: BYTE_W]),
      .keep_i (s1_keep_q[k]),
      .w_o    (dec_w[WBITS_PER_BYTE*k +: WBITS_PER_BYTE]),
      .err_o  (dec_err[k])
    );
  end

  assign s2_adv = ~s2_valid_q | out_ready;
  assign s1_adv = ~s1_valid_q | s2_adv;

  // Stage loads: S1 captures raw bytes, S2 captures decoded weights.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_keep_d  = s1_keep_q;
    s2_valid_d = s2_valid_q;
    s2_w_d     = s2_w_q;
    s2_err_d   = s2_err_q;
    s2_any_d   = s2_any_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_keep_d = in_keep;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_w_d   = dec_w;
        s2_err_d = dec_err;
        s2_any_d = |dec_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_keep_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_w_q     <= '0;
      s2_err_q   <= '0;
      s2_any_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_keep_q  <= s1_keep_d;
      s2_valid_q <= s2_valid_d;
      s2_w_q     <= s2_w_d;
      s2_err_q   <= s2_err_d;
      s2_any_q   <= s2_any_d;
    end
  end

  assign in_ready     = s1_adv;
  assign out_valid    = s2_valid_q;
  assign out_w        = s2_w_q;
  assign out_err_lane = s2_err_q;
  assign out_err      = s2_any_q;

`ifdef TERNARY_ERR_CNT_EN
  localparam int unsigned POP_W = $clog2(LANES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POP_W-1:0] pop;
  logic [CNT_W:0]   sum;

  // Saturating count of flagged lanes on delivered beats; clear has priority.
  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      pop = pop + POP_W'(s2_err_q[k]);
    end
    sum   = {1'b0, cnt_q} + (CNT_W + 1)'(pop);
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready) begin
      cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_cnt = cnt_q;
`endif

endmodule
